// File: rtl/hbm_rd_scheduler_pkg.sv
// Shared constants, AXI encodings and FSM state type for the HBM read-address scheduler.
package hbm_rd_scheduler_pkg;

    localparam int unsigned MEM_RD_A_TAG = 1;
    localparam int unsigned MEM_RD_B_TAG = 2;
    localparam int unsigned BEAT_BYTES   = 32;
    localparam int unsigned BEAT_SHIFT   = $clog2(BEAT_BYTES);

    localparam logic [2:0] AXI_ARSIZE_32B   = 3'b101;
    localparam logic [1:0] AXI_ARBURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    // Beats in the next burst: a full burst, or whatever is left.
    function automatic logic [4:0] burst_size(input logic [31:0] remaining,
                                              input int unsigned burst_len);
        if (remaining >= 32'(burst_len)) return 5'(burst_len);
        return remaining[4:0];
    endfunction

endpackage

// File: rtl/hbm_rd_credit.sv
// In-flight beat counter: grows on AR handshakes, shrinks on returned R beats,
// and reports whether a burst of a given size still fits under the cap.
module hbm_rd_credit #(
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ar_fire,
    input  logic [4:0] ar_size,
    input  logic       rd_beat,
    input  logic [4:0] size_a,
    input  logic [4:0] size_b,
    output logic       eligible_a,
    output logic       eligible_b,
    output logic       inflight_zero
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;
    logic [31:0]   grow;
    logic [31:0]   shrink;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        grow       = 32'd0;
        shrink     = 32'd0;
        if (ar_fire) grow = 32'(ar_size);
        // A stray beat with nothing outstanding is dropped rather than wrapping the counter.
        if (rd_beat && (inflight_q != '0)) shrink = 32'd1;
        inflight_d = CW'(32'(inflight_q) + grow - shrink);
    end

    // NOTE: sequential state uses non-blocking assignments and is cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight_q <= '0;
        else        inflight_q <= inflight_d;
    end

    assign eligible_a    = (32'(inflight_q) + 32'(size_a)) <= MAX_OUTSTANDING;
    assign eligible_b    = (32'(inflight_q) + 32'(size_b)) <= MAX_OUTSTANDING;
    assign inflight_zero = (inflight_q == '0);

endmodule

// File: rtl/hbm_rd_scheduler.sv
// AXI3 read-address generator for one HBM pseudo-channel: interleaves A and B
// fetch bursts under an in-flight beat credit limit.
module hbm_rd_scheduler
    import hbm_rd_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 33,
    parameter int unsigned ID_WIDTH        = 6,
    parameter int unsigned BURST_LEN       = 8,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] a_base_addr,
    input  logic [31:0]           a_length,
    input  logic [ADDR_WIDTH-1:0] b_base_addr,
    input  logic [31:0]           b_length,
    input  logic                  rd_beat,
    output logic                  m_axi_ARVALID,
    input  logic                  m_axi_ARREADY,
    output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
    output logic [3:0]            m_axi_ARLEN,
    output logic [ID_WIDTH-1:0]   m_axi_ARID,
    output logic [2:0]            m_axi_ARSIZE,
    output logic [1:0]            m_axi_ARBURST,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           ar_a_cnt,
    output logic [31:0]           ar_b_cnt
);

    sched_state_t state, state_nxt;

    logic [31:0]           rem_a, rem_b;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b;
    logic [4:0]            size_a, size_b, ar_size;
    logic                  ar_sel_b;
    logic                  prefer_b;
    logic                  elig_a, elig_b, inflight_zero;
    logic                  can_a, can_b, pick_a, pick_b;
    logic                  ar_fire, start_ok;

    assign size_a   = burst_size(rem_a, BURST_LEN);
    assign size_b   = burst_size(rem_b, BURST_LEN);
    assign can_a    = (rem_a != 32'd0) && elig_a;
    assign can_b    = (rem_b != 32'd0) && elig_b;
    // With both requesters ready, the one not served last wins; prefer_b starts at 0 so A goes first.
    assign pick_a   = (state == ST_ARB) && can_a && (!can_b || !prefer_b);
    assign pick_b   = (state == ST_ARB) && can_b && !pick_a;
    assign ar_fire  = m_axi_ARVALID && m_axi_ARREADY;
    assign start_ok = start && (state == ST_IDLE);

    hbm_rd_credit #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk          (clk),
        .rst_n        (rst_n),
        .ar_fire      (ar_fire),
        .ar_size      (ar_size),
        .rd_beat      (rd_beat),
        .size_a       (size_a),
        .size_b       (size_b),
        .eligible_a   (elig_a),
        .eligible_b   (elig_b),
        .inflight_zero(inflight_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_ARB;
            ST_ARB: begin
                if ((rem_a == 32'd0) && (rem_b == 32'd0)) state_nxt = ST_DRAIN;
                else if (pick_a || pick_b)                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: if (m_axi_ARREADY) state_nxt = ST_ARB;
            ST_DRAIN: if (inflight_zero) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_a        <= '0;
            rem_b        <= '0;
            addr_a       <= '0;
            addr_b       <= '0;
            ar_a_cnt     <= '0;
            ar_b_cnt     <= '0;
            prefer_b     <= 1'b0;
            ar_sel_b     <= 1'b0;
            ar_size      <= '0;
            m_axi_ARADDR <= '0;
            m_axi_ARLEN  <= '0;
            m_axi_ARID   <= '0;
        end else begin
            if (start_ok) begin
                rem_a    <= a_length >> BEAT_SHIFT;
                rem_b    <= b_length >> BEAT_SHIFT;
                addr_a   <= a_base_addr;
                addr_b   <= b_base_addr;
                ar_a_cnt <= '0;
                ar_b_cnt <= '0;
                prefer_b <= 1'b0;
            end

            // AR fields are captured once at the pick and held through the whole ISSUE wait.
            if (pick_a) begin
                m_axi_ARADDR <= addr_a;
                m_axi_ARLEN  <= 4'(size_a - 5'd1);
                m_axi_ARID   <= ID_WIDTH'(MEM_RD_A_TAG);
                ar_size      <= size_a;
                ar_sel_b     <= 1'b0;
                prefer_b     <= 1'b1;
            end else if (pick_b) begin
                m_axi_ARADDR <= addr_b;
                m_axi_ARLEN  <= 4'(size_b - 5'd1);
                m_axi_ARID   <= ID_WIDTH'(MEM_RD_B_TAG);
                ar_size      <= size_b;
                ar_sel_b     <= 1'b1;
                prefer_b     <= 1'b0;
            end

            if (ar_fire) begin
                if (ar_sel_b) begin
                    rem_b    <= rem_b - 32'(ar_size);
                    addr_b   <= addr_b + (ADDR_WIDTH'(ar_size) << BEAT_SHIFT);
                    ar_b_cnt <= ar_b_cnt + 32'd1;
                end else begin
                    rem_a    <= rem_a - 32'(ar_size);
                    addr_a   <= addr_a + (ADDR_WIDTH'(ar_size) << BEAT_SHIFT);
                    ar_a_cnt <= ar_a_cnt + 32'd1;
                end
            end
        end
    end

    assign m_axi_ARVALID = (state == ST_ISSUE);
    assign m_axi_ARSIZE  = AXI_ARSIZE_32B;
    assign m_axi_ARBURST = AXI_ARBURST_INCR;
    assign busy          = (state == ST_ARB) || (state == ST_ISSUE) || (state == ST_DRAIN);
    assign done          = (state == ST_DONE);

endmodule

// File: tb/tb_hbm_rd_scheduler.sv
// Randomized scoreboard bench for hbm_rd_scheduler: per-tag burst lists from a
// transaction-level model, a credit model, and directed corner cases.
`timescale 1ns/1ps
module tb_hbm_rd_scheduler;
    import hbm_rd_scheduler_pkg::*;

    localparam int AW = 33;
    localparam int IW = 6;
    localparam int BL = 8;
    localparam int MO = 16;
    localparam int RET_DELAY = 10;

    logic          clk, rst_n, start, rd_beat;
    logic [AW-1:0] a_base_addr, b_base_addr;
    logic [31:0]   a_length, b_length;
    logic          m_axi_ARVALID, m_axi_ARREADY;
    logic [AW-1:0] m_axi_ARADDR;
    logic [3:0]    m_axi_ARLEN;
    logic [IW-1:0] m_axi_ARID;
    logic [2:0]    m_axi_ARSIZE;
    logic [1:0]    m_axi_ARBURST;
    logic          busy, done;
    logic [31:0]   ar_a_cnt, ar_b_cnt;

    hbm_rd_scheduler #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BURST_LEN(BL), .MAX_OUTSTANDING(MO)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_base_addr(a_base_addr), .a_length(a_length),
        .b_base_addr(b_base_addr), .b_length(b_length),
        .rd_beat(rd_beat),
        .m_axi_ARVALID(m_axi_ARVALID), .m_axi_ARREADY(m_axi_ARREADY),
        .m_axi_ARADDR(m_axi_ARADDR), .m_axi_ARLEN(m_axi_ARLEN),
        .m_axi_ARID(m_axi_ARID), .m_axi_ARSIZE(m_axi_ARSIZE),
        .m_axi_ARBURST(m_axi_ARBURST),
        .busy(busy), .done(done), .ar_a_cnt(ar_a_cnt), .ar_b_cnt(ar_b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    len;
    } burst_t;

    burst_t      exp_a[$];
    burst_t      exp_b[$];
    int unsigned order_q[$];
    int          beat_due[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tb_inflight = 0;
    int done_cnt    = 0;
    int ready_pct   = 100;
    int exp_na, exp_nb;
    bit ret_en      = 1'b1;
    bit force_beat  = 1'b0;
    bit stray_beat  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        m_axi_ARREADY = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            m_axi_ARREADY = (int'($urandom_range(99)) < ready_pct);
        end
    end

    // Read-data return model: each issued beat comes back RET_DELAY cycles later, one per cycle.
    initial begin
        rd_beat = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (stray_beat) begin
                rd_beat = 1'b1;
            end else if (beat_due.size() > 0 && (force_beat || (ret_en && beat_due[0] <= cyc))) begin
                rd_beat = 1'b1;
                void'(beat_due.pop_front());
            end else begin
                rd_beat = 1'b0;
            end
        end
    end

    // Monitor: samples mid-cycle, compares each AR handshake against the expected burst lists.
    initial begin
        burst_t        e;
        int            sz;
        bit            prev_wait;
        logic [AW-1:0] p_addr;
        logic [3:0]    p_len;
        logic [IW-1:0] p_id;
        prev_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wait = 1'b0;
                continue;
            end
            if (m_axi_ARVALID && prev_wait) begin
                check("hold_addr", m_axi_ARADDR, p_addr);
                check("hold_len", m_axi_ARLEN, p_len);
                check("hold_id", m_axi_ARID, p_id);
            end
            sz = int'(m_axi_ARLEN) + 1;
            if (m_axi_ARVALID && m_axi_ARREADY) begin
                check("arsize", m_axi_ARSIZE, 3'b101);
                check("arburst", m_axi_ARBURST, 2'b01);
                check("credit_limit", (tb_inflight + sz) <= MO, 1'b1);
                if (m_axi_ARID == IW'(MEM_RD_A_TAG)) begin
                    check("burst_a_expected", exp_a.size() != 0, 1'b1);
                    if (exp_a.size() != 0) begin
                        e = exp_a.pop_front();
                        check("araddr_a", m_axi_ARADDR, e.addr);
                        check("arlen_a", m_axi_ARLEN, e.len);
                    end
                end else if (m_axi_ARID == IW'(MEM_RD_B_TAG)) begin
                    check("burst_b_expected", exp_b.size() != 0, 1'b1);
                    if (exp_b.size() != 0) begin
                        e = exp_b.pop_front();
                        check("araddr_b", m_axi_ARADDR, e.addr);
                        check("arlen_b", m_axi_ARLEN, e.len);
                    end
                end else begin
                    check("arid_valid", m_axi_ARID, IW'(MEM_RD_A_TAG));
                end
                order_q.push_back(int'(m_axi_ARID));
            end
            if (rd_beat && tb_inflight > 0) tb_inflight--;
            if (m_axi_ARVALID && m_axi_ARREADY) begin
                tb_inflight += sz;
                for (int i = 0; i < sz; i++) beat_due.push_back(cyc + RET_DELAY);
            end
            if (done) begin
                done_cnt++;
                check("done_inflight_zero", tb_inflight, 0);
            end
            prev_wait = m_axi_ARVALID && !m_axi_ARREADY;
            p_addr = m_axi_ARADDR;
            p_len  = m_axi_ARLEN;
            p_id   = m_axi_ARID;
        end
    end

    // Reference: split a region into bursts of min(BL, remaining) beats.
    task automatic model_push(input bit is_b, input logic [AW-1:0] base,
                              input int unsigned len, output int nb);
        int unsigned beats, off, sz;
        burst_t e;
        beats = len / 32;
        off   = 0;
        nb    = 0;
        while (beats > 0) begin
            sz     = (beats < BL) ? beats : BL;
            e.addr = base + AW'(off);
            e.len  = 4'(sz - 1);
            if (is_b) exp_b.push_back(e);
            else      exp_a.push_back(e);
            off   += sz * 32;
            beats -= sz;
            nb++;
        end
    endtask

    task automatic launch_op(input logic [AW-1:0] ab, input int unsigned al,
                             input logic [AW-1:0] bb, input int unsigned bl);
        model_push(1'b0, ab, al, exp_na);
        model_push(1'b1, bb, bl, exp_nb);
        @(posedge clk);
        #1;
        start       = 1'b1;
        a_base_addr = ab;
        a_length    = al;
        b_base_addr = bb;
        b_length    = bl;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Entered one cycle after the start edge; lat counts cycles from the start pulse.
    task automatic wait_done(input int limit, output int lat);
        lat = 1;
        while (!done && lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic finish_op(input int done_before);
        check("ar_a_cnt", ar_a_cnt, exp_na);
        check("ar_b_cnt", ar_b_cnt, exp_nb);
        @(posedge clk);
        #1;
        check("busy_after_done", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
        check("done_pulse_count", done_cnt, done_before + 1);
        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
    endtask

    initial begin
        int lat, d0, applied, first;
        logic [AW-1:0] ba, bb;
        int unsigned la, lb;

        rst_n = 1'b0;
        start = 1'b0;
        a_base_addr = '0; b_base_addr = '0;
        a_length = '0;    b_length = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arvalid", m_axi_ARVALID, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ar_a_cnt", ar_a_cnt, 0);
        check("rst_araddr", m_axi_ARADDR, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single A region, full bursts, with the 2-cycle start-to-ARVALID latency.
        d0 = done_cnt;
        launch_op(33'h1_2345_6000, 1024, 33'h0_0000_0000, 0);
        check("lat_arb_cycle", m_axi_ARVALID, 1'b0);
        check("busy_after_start", busy, 1'b1);
        @(posedge clk);
        #1;
        check("lat_first_arvalid", m_axi_ARVALID, 1'b1);
        wait_done(2000, lat);
        finish_op(d0);

        // Both regions pending: strict A,B,A,B interleave.
        order_q.delete();
        d0 = done_cnt;
        launch_op(33'h0_1000_0000, 512, 33'h1_8000_0000, 512);
        wait_done(2000, lat);
        finish_op(d0);
        check("order_len", order_q.size(), 4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            check("order_tag", order_q[i], (i % 2 == 0) ? MEM_RD_A_TAG : MEM_RD_B_TAG);

        // Short trailing burst.
        d0 = done_cnt;
        launch_op(33'h0_0ABC_D000, 320, 33'h0_0000_0000, 0);
        wait_done(2000, lat);
        finish_op(d0);

        // Both lengths zero: done exactly 3 cycles after start.
        d0 = done_cnt;
        launch_op(33'h0_0000_1000, 0, 33'h0_0000_2000, 0);
        wait_done(20, lat);
        check("zero_len_latency", lat, 3);
        finish_op(d0);

        // Credit exhaustion: two bursts fill MO=16, then eight returns re-open one burst.
        order_q.delete();
        ret_en = 1'b0;
        d0 = done_cnt;
        launch_op(33'h0_2000_0000, 1024, 33'h0_0000_0000, 0);
        repeat (25) @(posedge clk);
        #1;
        check("stall_burst_count", order_q.size(), 2);
        check("stall_arvalid_low", m_axi_ARVALID, 1'b0);
        force_beat = 1'b1;
        applied = 0;
        first   = -1;
        for (int j = 0; j < 20 && first < 0; j++) begin
            @(posedge clk);
            #1;
            if (rd_beat) applied++;
            if (m_axi_ARVALID) first = applied;
        end
        force_beat = 1'b0;
        ret_en     = 1'b1;
        // Eighth return frees credit; the pick cycle overlaps the ninth.
        check("resume_after_8_returns", first, 9);
        wait_done(2000, lat);
        finish_op(d0);

        // ARREADY held low: fields stable, and a start pulse while busy is ignored.
        ready_pct = 0;
        d0 = done_cnt;
        launch_op(33'h0_3000_0000, 512, 33'h0_4000_0000, 256);
        for (int j = 0; j < 10 && !m_axi_ARVALID; j++) begin
            @(posedge clk);
            #1;
        end
        for (int j = 0; j < 5; j++) begin
            check("stall_arvalid_high", m_axi_ARVALID, 1'b1);
            check("stall_busy", busy, 1'b1);
            if (j == 2) begin
                start       = 1'b1;
                a_base_addr = 33'h0_5000_0000;
                a_length    = 4096;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        ready_pct = 70;
        wait_done(2000, lat);
        finish_op(d0);

        // Asynchronous reset while a burst waits in ISSUE.
        ready_pct = 100;
        launch_op(33'h0_6000_0000, 1024, 33'h0_0000_0000, 0);
        for (int j = 0; j < 20 && ar_a_cnt == 0; j++) begin
            @(posedge clk);
            #1;
        end
        ready_pct = 0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_arvalid", m_axi_ARVALID, 1'b1);
        check("pre_rst_cnt", ar_a_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_arvalid", m_axi_ARVALID, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_cnt", ar_a_cnt, 0);
        exp_a.delete();
        exp_b.delete();
        beat_due.delete();
        tb_inflight = 0;
        @(negedge clk);
        rst_n = 1'b1;
        // Stray beats with nothing in flight must not underflow the credit counter.
        @(posedge clk);
        #1;
        stray_beat = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stray_beat = 1'b0;
        ready_pct  = 100;
        d0 = done_cnt;
        launch_op(33'h0_7000_0000, 512, 33'h0_7100_0000, 512);
        wait_done(2000, lat);
        finish_op(d0);

        // Randomized regions and ARREADY throttling.
        for (int r = 0; r < 8; r++) begin
            ba = AW'($urandom_range(0, 2097151)) << 12;
            bb = AW'($urandom_range(0, 2097151)) << 12;
            la = $urandom_range(0, 40) * 32;
            lb = $urandom_range(0, 40) * 32;
            ready_pct = $urandom_range(30, 100);
            d0 = done_cnt;
            launch_op(ba, la, bb, lb);
            wait_done(4000, lat);
            finish_op(d0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
